// File: rtl/kmp_prefix_ctrl.sv
// KMP search sequencer: loads the pattern ROM, builds the LPS table, then scans the text ROM.
// Define KMP_MATCH_POS_EN to add the match_valid/match_pos outputs.
module kmp_prefix_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PAT_LEN  = 4,
  parameter int PAT_AW   = 3,
  parameter int TEXT_LEN = 56,
  parameter int TEXT_AW  = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PAT_AW-1:0]  pat_addr,
  input  logic [DATA_W-1:0]  pat_data,
  output logic [TEXT_AW-1:0] txt_addr,
  input  logic [DATA_W-1:0]  txt_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count
`ifdef KMP_MATCH_POS_EN
  ,
  output logic               match_valid,
  output logic [TEXT_AW-1:0] match_pos
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, BUILD, FETCH, CMP, FIN} state_t;

  localparam logic [PAT_AW:0]    PLEN  = (PAT_AW+1)'(PAT_LEN);
  localparam logic [PAT_AW-1:0]  PLAST = PAT_AW'(PAT_LEN - 1);
  localparam logic [TEXT_AW-1:0] TLAST = TEXT_AW'(TEXT_LEN - 1);
  localparam logic [TEXT_AW-1:0] TOFF  = TEXT_AW'(PAT_LEN - 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] pat [2**PAT_AW];
  logic [PAT_AW-1:0] lps [2**PAT_AW];
  logic [PAT_AW:0]   k;
  logic [PAT_AW-1:0] len;
  logic [PAT_AW-1:0] j;
  logic [TEXT_AW-1:0] i;
  logic [DATA_W-1:0] c;
  logic              first;

  logic [PAT_AW-1:0] k_idx, ld_prev;
  logic [PAT_AW:0]   k_inc;
  logic [DATA_W-1:0] ch;
  logic              b_eq, hit, j_full, i_last, cmp_adv;

  always_comb begin
    k_idx   = k[PAT_AW-1:0];
    k_inc   = k + 1'b1;
    ld_prev = k_idx - 1'b1;
    // Text data lands in the first CMP cycle; later CMP cycles reuse the held copy.
    ch      = first ? txt_data : c;
    b_eq    = (pat[k_idx] == pat[len]);
    hit     = (ch == pat[j]);
    j_full  = (j == PLAST);
    i_last  = (i == TLAST);
    cmp_adv = hit || (j == '0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (k == PLEN) state_nx = BUILD;
      BUILD: if ((b_eq || len == '0) && k_inc == PLEN) state_nx = FETCH;
      FETCH: state_nx = CMP;
      CMP:   if (cmp_adv) state_nx = i_last ? FIN : FETCH;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == BUILD) || (state == FETCH) || (state == CMP);
  assign done = (state == FIN);

`ifdef KMP_MATCH_POS_EN
  logic [TEXT_AW-1:0] pos_q;
  assign match_valid = (state == CMP) && hit && j_full;
  assign match_pos   = match_valid ? (i - TOFF) : pos_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_addr    <= '0;
      txt_addr    <= '0;
      match_count <= '0;
      pat         <= '{default: '0};
      lps         <= '{default: '0};
      k           <= '0;
      len         <= '0;
      i           <= '0;
      j           <= '0;
      c           <= '0;
      first       <= 1'b0;
`ifdef KMP_MATCH_POS_EN
      pos_q       <= '0;
`endif
    end else begin
      state <= state_nx;
      first <= (state == FETCH);
      case (state)
        IDLE: if (start) begin
          match_count <= '0;
          pat_addr    <= '0;
          k           <= '0;
        end
        LOAD: begin
          // k is the address issued this cycle; the data returned belongs to k-1.
          if (k != '0) pat[ld_prev] <= pat_data;
          if (k_inc < PLEN) pat_addr <= k_inc[PAT_AW-1:0];
          if (k == PLEN) begin
            k      <= (PAT_AW+1)'(1);
            len    <= '0;
            lps[0] <= '0;
          end else begin
            k <= k_inc;
          end
        end
        BUILD: begin
          if (b_eq) begin
            lps[k_idx] <= len + 1'b1;
            len        <= len + 1'b1;
            k          <= k_inc;
          end else if (len != '0) begin
            len <= lps[len - 1'b1];
          end else begin
            lps[k_idx] <= '0;
            k          <= k_inc;
          end
          if (state_nx == FETCH) begin
            i        <= '0;
            j        <= '0;
            txt_addr <= '0;
          end
        end
        CMP: begin
          c <= ch;
          if (hit) begin
            if (j_full) begin
              if (match_count != '1) match_count <= match_count + 1'b1;
              j <= lps[PLAST];
`ifdef KMP_MATCH_POS_EN
              pos_q <= i - TOFF;
`endif
            end else begin
              j <= j + 1'b1;
            end
          end else if (j != '0) begin
            j <= lps[j - 1'b1];
          end
          if (cmp_adv) begin
            i <= i + 1'b1;
            if (!i_last) txt_addr <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_prefix_ctrl.sv
// Directed + random bench for kmp_prefix_ctrl; a CNT_W=4 copy runs alongside to cover saturation.
module tb_kmp_prefix_ctrl;
  localparam int P = 4;
  localparam int T = 56;

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] pat_addr, pat_addr4;
  logic [7:0] pat_data, pat_data4, txt_data, txt_data4;
  logic [7:0] txt_addr, txt_addr4;
  logic busy, busy4, done, done4;
  logic [7:0] match_count;
  logic [3:0] match_count4;
`ifdef KMP_MATCH_POS_EN
  logic mv, mv4;
  logic [7:0] mp, mp4;
`endif

  logic [7:0] pmem [8];
  logic [7:0] tmem [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pat_data  <= pmem[pat_addr];
    txt_data  <= tmem[txt_addr];
    pat_data4 <= pmem[pat_addr4];
    txt_data4 <= tmem[txt_addr4];
  end

  kmp_prefix_ctrl #(.DATA_W(8), .PAT_LEN(P), .PAT_AW(3), .TEXT_LEN(T), .TEXT_AW(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_addr(pat_addr), .pat_data(pat_data),
    .txt_addr(txt_addr), .txt_data(txt_data), .busy(busy), .done(done), .match_count(match_count)
`ifdef KMP_MATCH_POS_EN
    , .match_valid(mv), .match_pos(mp)
`endif
  );

  kmp_prefix_ctrl #(.DATA_W(8), .PAT_LEN(P), .PAT_AW(3), .TEXT_LEN(T), .TEXT_AW(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .pat_addr(pat_addr4), .pat_data(pat_data4),
    .txt_addr(txt_addr4), .txt_data(txt_data4), .busy(busy4), .done(done4), .match_count(match_count4)
`ifdef KMP_MATCH_POS_EN
    , .match_valid(mv4), .match_pos(mp4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Longest proper prefix of pattern[0..q] that is also its suffix, by brute force.
  function automatic int naive_lps(int q);
    for (int l = q; l >= 1; l--) begin
      bit ok = 1'b1;
      for (int x = 0; x < l; x++)
        if (pmem[x] != pmem[q-l+1+x]) ok = 1'b0;
      if (ok) return l;
    end
    return 0;
  endfunction

  function automatic bit match_at(int s);
    for (int x = 0; x < P; x++)
      if (pmem[x] != tmem[s+x]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int s = 0; s <= T - P; s++) if (match_at(s)) n++;
    return n;
  endfunction

  // Cycles from the start-sampling edge (counted as 1) to the cycle done is seen.
  function automatic int model_cycles();
    int bld = 0, ln = 0, kk = 1, txt = 0, jj = 0;
    while (kk < P) begin
      bld++;
      if (pmem[kk] == pmem[ln]) begin ln++; kk++; end
      else if (ln > 0) ln = naive_lps(ln - 1);
      else kk++;
    end
    for (int ii = 0; ii < T; ii++) begin
      txt++;
      forever begin
        txt++;
        if (tmem[ii] == pmem[jj]) begin
          jj = (jj == P - 1) ? naive_lps(P - 1) : jj + 1;
          break;
        end else if (jj > 0) jj = naive_lps(jj - 1);
        else break;
      end
    end
    return P + bld + txt + 2;
  endfunction

  task automatic set_pat(input string s);
    for (int x = 0; x < P; x++) pmem[x] = s[x];
  endtask

  task automatic set_text(input string unit);
    for (int x = 0; x < T; x++) tmem[x] = unit[x % unit.len()];
  endtask

  task automatic run_check(input string tag, input bit again);
    int cyc = 1, n_done = 0, exp_cnt, exp_cyc, addr_err = 0, exp_addr;
    logic [7:0] prev_addr;
    int pos_q[$];
    exp_cnt   = model_count();
    exp_cyc   = model_cycles();
    prev_addr = txt_addr;
    exp_addr  = (txt_addr == 8'd0) ? 1 : 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = (again && cyc == 10);
      if (txt_addr != prev_addr) begin
        if (int'(txt_addr) != exp_addr) addr_err++;
        exp_addr++;
        prev_addr = txt_addr;
      end
`ifdef KMP_MATCH_POS_EN
      if (mv) pos_q.push_back(int'(mp));
`endif
    end
    start = 1'b0;
    chk({tag, ":done"}, {31'd0, done}, 32'd1);
    chk({tag, ":latency"}, cyc, exp_cyc);
    chk({tag, ":count"}, {24'd0, match_count}, exp_cnt);
    chk({tag, ":count4"}, {28'd0, match_count4}, (exp_cnt > 15) ? 15 : exp_cnt);
    chk({tag, ":done4"}, {31'd0, done4}, 32'd1);
    chk({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, ":addr_order"}, addr_err, 0);
    chk({tag, ":addr_last"}, exp_addr, T);
`ifdef KMP_MATCH_POS_EN
    begin
      int perr = 0, pi = 0;
      for (int s = 0; s <= T - P; s++)
        if (match_at(s)) begin
          if (pi >= pos_q.size() || pos_q[pi] != s) perr++;
          pi++;
        end
      chk({tag, ":pos_n"}, pos_q.size(), exp_cnt);
      chk({tag, ":pos_val"}, perr, 0);
    end
`endif
    repeat (20) @(negedge clk) if (done) n_done++;
    chk({tag, ":extra_done"}, n_done, 0);
    chk({tag, ":count_hold"}, {24'd0, match_count}, exp_cnt);
  endtask

  initial begin
    int cyc, n;
    for (int x = 0; x < 256; x++) tmem[x] = 8'd0;
    for (int x = 0; x < 8; x++) pmem[x] = 8'd0;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:busy", {31'd0, busy}, 0);
    chk("rst:done", {31'd0, done}, 0);
    chk("rst:count", {24'd0, match_count}, 0);
    chk("rst:pat_addr", {29'd0, pat_addr}, 0);
    chk("rst:txt_addr", {24'd0, txt_addr}, 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_wins_start", {31'd0, busy}, 0);

    set_pat("ABAB"); set_text("AB"); run_check("abab", 1'b0);
    set_pat("AAAA"); set_text("A");  run_check("aaaa", 1'b0);
    set_pat("AABA"); set_text("C");  run_check("aaba", 1'b0);
    set_pat("ABAB"); set_text("AB"); run_check("restart", 1'b1);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (txt_addr != 8'd20 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("midrst:reached", {24'd0, txt_addr}, 20);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst:busy", {31'd0, busy}, 0);
    chk("midrst:count", {24'd0, match_count}, 0);
    chk("midrst:txt_addr", {24'd0, txt_addr}, 0);
    rst = 1'b0;
    n = 0;
    repeat (300) @(negedge clk) if (done || busy) n++;
    chk("midrst:quiet", n, 0);
    run_check("after_rst", 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < P; x++) pmem[x] = 8'h41 + 8'($urandom_range(0, 1));
      for (int x = 0; x < T; x++) tmem[x] = 8'h41 + 8'($urandom_range(0, (r < 3) ? 1 : 2));
      run_check($sformatf("rand%0d", r), r == 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kmp_prefix_ctrl.md
Name: kmp_prefix_ctrl

Overview:
- Sequencer for the full Knuth-Morris-Pratt search over the existing pattern and text ROMs.
- Runs three phases in order:
  - copies the pattern ROM into internal registers;
  - builds the prefix (failure/LPS) table;
  - scans the text ROM using the table, so no text character is re-fetched after a mismatch.
- Replaces restart-from-zero matching and reports the overlapping match count to the board-level display logic.

Parameters:
- DATA_W, 8, character width in bits
- PAT_LEN, 4, pattern length in characters (2..2^PAT_AW)
- PAT_AW, 3, pattern ROM address width
- TEXT_LEN, 56, text length in characters (1..2^TEXT_AW)
- TEXT_AW, 8, text ROM address width
- CNT_W, 8, match counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run a complete search
- pat_addr  out  PAT_AW  pattern ROM address
- pat_data  in  DATA_W  pattern ROM data; valid the cycle after pat_addr is presented
- txt_addr  out  TEXT_AW  text ROM address
- txt_data  in  DATA_W  text ROM data; valid the cycle after txt_addr is presented
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the search completes
- match_count  out  CNT_W  matches found in the last or current run, saturating

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE;
  - pat_addr=0, txt_addr=0;
  - busy=0, done=0, match_count=0;
  - LPS table, pattern registers, indices i/j all cleared.
  - Reset asserted mid-run aborts immediately to this state; no done pulse.
- ROMs are synchronous with 1-cycle read latency. The controller never uses data in the same cycle its address is issued.
- IDLE:
  - start=1 clears match_count, sets busy, goes to LOAD.
  - start is ignored in every other state.
- LOAD:
  - Issues pat_addr 0..PAT_LEN-1 on consecutive cycles.
  - Captures pat_data one cycle later into pat[k].
  - Takes PAT_LEN+1 cycles, then goes to BUILD with len=0, k=1, lps[0]=0.
- BUILD (one comparison per cycle, internal registers only):
  - pat[k]==pat[len]: lps[k]=len+1; len++; k++.
  - Else if len>0: len=lps[len-1]; k unchanged.
  - Else: lps[k]=0; k++.
  - Leaves to FETCH with j=0, i=0 when k==PAT_LEN.
- FETCH: drives txt_addr=i, then goes to CMP on the next cycle. Text data is registered into a held char c.
- CMP:
  - c==pat[j] and j+1==PAT_LEN: match_count++ (saturates at all-ones); j=lps[PAT_LEN-1]; advance.
  - c==pat[j] otherwise: j++; advance.
  - Mismatch with j>0: j=lps[j-1]; stay in CMP comparing the same held c. No refetch.
  - Mismatch with j==0: advance.
- Advance: i++. If i was TEXT_LEN-1, go to FIN; else go to FETCH.
- FIN: done=1 for one cycle, busy=0, return to IDLE. match_count holds until the next accepted start.
- start coincident with rst: rst wins.
- Overlapping matches are counted.
- Address outputs hold their last value while not fetching.

Optional Feature:
- Macro: KMP_MATCH_POS_EN.
- Defined:
  - Adds output match_valid (1 bit): one-cycle pulse in the CMP cycle that completes a match.
  - Adds output match_pos (TEXT_AW bits): start index of that match, i-(PAT_LEN-1); holds its value between pulses; reset 0.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Pattern "ABAB", text "AB" repeated 28 times (56 chars), pulse start -> after LOAD/BUILD, lps internal = {0,0,1,2}; done pulses once; match_count=27. With KMP_MATCH_POS_EN: match_pos pulses 0,2,4,...,52.
- Pattern "AAAA", text 56 x 'A' -> match_count=53; txt_addr covers 0..55 each exactly once.
- Pattern "AABA", text 56 x 'C' -> lps={0,1,0,1}; match_count=0; done asserted exactly TEXT_LEN*2+PAT_LEN+1+(BUILD cycles)+1 cycles after start.
- CNT_W=4, pattern "AAAA", text all 'A' -> match_count saturates at 15, no wrap.
- Start pulsed again while busy -> ignored, single done, count unchanged from single-run result.
- rst asserted during FETCH/CMP of text index 20 -> next cycle busy=0, match_count=0, done never pulses. A following start runs a full correct search.
